hit_judge: RTL and testbench

Parametrised, clocked note-judgement and scoring block for the drum-game datapath. It replaces the per-cycle combinational compare between note lanes and player buttons. For each note slot it opens a timing window, detects button press edges per lane, and grades the hit as PERFECT, GOOD, MISS or STRAY. It also keeps the running score, the current combo and the maximum combo that the display and HUD logic read.

---
 rtl/hit_judge.sv | 215 +++++++++++++++++++++
 tb/tb_hit_judge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// ---------------------------------------------------------------------------
// hit_judge
// Clocked note-judgement and scoring block for the drum-game datapath.
// Opens a timing window per note slot, detects button press edges per lane,
// grades each note as PERFECT / GOOD / MISS / STRAY and keeps the running
// score, current combo and maximum combo.
//
// Ports
//   clk          : system clock, rising edge
//   resetn       : asynchronous active-low reset
//   clear        : synchronous restart (score, combo, FSM back to zero/IDLE)
//   beat_tick    : one-cycle pulse, a note slot reaches the hit line
//   notes        : note pattern at the hit line, sampled on beat_tick
//   player_input : button levels, active-high, already synchronised
//   judge_valid  : one-cycle pulse per judgement
//   judge_code   : 00 PERFECT, 01 GOOD, 10 MISS, 11 STRAY (held between pulses)
//   score        : running score, saturating at both ends
//   combo        : consecutive PERFECT/GOOD count, saturating
//   max_combo    : highest combo since reset or clear
// ---------------------------------------------------------------------------
module hit_judge #(
    parameter int LANES       = 3,
    parameter int PERFECT_WIN = 2,
    parameter int GOOD_WIN    = 6,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int PTS_PERFECT = 3,
    parameter int PTS_GOOD    = 1,
    parameter int PTS_MISS    = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               beat_tick,
    input  logic [LANES-1:0]   notes,
    input  logic [LANES-1:0]   player_input,
    output logic               judge_valid,
    output logic [1:0]         judge_code,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

    localparam int AGE_W = $clog2(GOOD_WIN + 1);
    localparam logic [AGE_W-1:0]   AGE_PERF  = AGE_W'(PERFECT_WIN);
    localparam logic [AGE_W-1:0]   AGE_GOOD  = AGE_W'(GOOD_WIN);
    localparam logic [AGE_W-1:0]   AGE_ONE   = AGE_W'(1);
    localparam logic [SCORE_W:0]   PTS_P_W   = (SCORE_W+1)'(PTS_PERFECT);
    localparam logic [SCORE_W:0]   PTS_G_W   = (SCORE_W+1)'(PTS_GOOD);
    localparam logic [SCORE_W:0]   PTS_M_W   = (SCORE_W+1)'(PTS_MISS);

    localparam logic [1:0] C_PERFECT = 2'b00;
    localparam logic [1:0] C_GOOD    = 2'b01;
    localparam logic [1:0] C_MISS    = 2'b10;
    localparam logic [1:0] C_STRAY   = 2'b11;

    typedef enum logic {S_IDLE, S_OPEN} state_t;

    state_t             r_state, w_state_nx;
    logic [LANES-1:0]   r_prev_in;
    logic [LANES-1:0]   r_pend, w_pend_nx;
    logic [LANES-1:0]   r_hit, w_hit_nx;
    logic [AGE_W-1:0]   r_age, w_age_nx;
    logic               r_valid;
    logic [1:0]         r_code;
    logic [SCORE_W-1:0] r_score, w_score_nx;
    logic [COMBO_W-1:0] r_combo, w_combo_nx;
    logic [COMBO_W-1:0] r_max, w_max_nx;

    logic               w_fire;
    logic [1:0]         w_code;
    logic [LANES-1:0]   w_press;
    logic [LANES-1:0]   w_h;
    logic               w_stray;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + b;
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] d;
        d = {1'b0, a} - b;
        return ({1'b0, a} < b) ? '0 : d[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] a);
        return (&a) ? a : a + COMBO_W'(1);
    endfunction

    always_comb begin
        w_press    = player_input & ~r_prev_in;
        w_h        = r_hit | (w_press & r_pend);
        w_stray    = |(w_press & ~r_pend);
        w_state_nx = r_state;
        w_pend_nx  = r_pend;
        w_hit_nx   = r_hit;
        w_age_nx   = r_age;
        w_fire     = 1'b0;
        w_code     = r_code;

        if (r_state == S_IDLE) begin
            if (beat_tick) begin
                if (|notes) begin
                    // Presses in the tick cycle are graded against the incoming note at age 0.
                    if (|(w_press & ~notes)) begin
                        w_fire = 1'b1;
                        w_code = C_MISS;
                    end else if ((w_press & notes) == notes) begin
                        w_fire = 1'b1;
                        w_code = C_PERFECT;
                    end else begin
                        w_state_nx = S_OPEN;
                        w_pend_nx  = notes;
                        w_hit_nx   = w_press & notes;
                        w_age_nx   = AGE_ONE;
                    end
                end
            end else if (|w_press) begin
                w_fire = 1'b1;
                w_code = C_STRAY;
            end
        end else begin
            w_state_nx = S_IDLE;
            w_pend_nx  = '0;
            w_hit_nx   = '0;
            w_age_nx   = '0;
            if (w_stray) begin
                w_fire = 1'b1;
                w_code = C_MISS;
            end else if (w_h == r_pend) begin
                w_fire = 1'b1;
                w_code = (r_age <= AGE_PERF) ? C_PERFECT : C_GOOD;
            end else if (r_age == AGE_GOOD || beat_tick) begin
                // Timeout, or a new slot arrives before the old note completes.
                w_fire = 1'b1;
                w_code = C_MISS;
            end else begin
                w_state_nx = S_OPEN;
                w_pend_nx  = r_pend;
                w_hit_nx   = w_h;
                w_age_nx   = r_age + AGE_ONE;
            end
            // The new note always opens clean; presses this cycle belonged to the old one.
            if (beat_tick && |notes) begin
                w_state_nx = S_OPEN;
                w_pend_nx  = notes;
                w_hit_nx   = '0;
                w_age_nx   = AGE_ONE;
            end
        end

        w_score_nx = r_score;
        w_combo_nx = r_combo;
        w_max_nx   = r_max;
        if (w_fire) begin
            if (w_code == C_PERFECT || w_code == C_GOOD) begin
                w_score_nx = sat_add(r_score, (w_code == C_PERFECT) ? PTS_P_W : PTS_G_W);
                w_combo_nx = sat_inc(r_combo);
                w_max_nx   = (w_combo_nx > r_max) ? w_combo_nx : r_max;
            end else begin
                w_score_nx = sat_sub(r_score, PTS_M_W);
                w_combo_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_prev_in <= '0;
            r_pend    <= '0;
            r_hit     <= '0;
            r_age     <= '0;
            r_valid   <= 1'b0;
            r_code    <= C_PERFECT;
            r_score   <= '0;
            r_combo   <= '0;
            r_max     <= '0;
        end else if (clear) begin
            // prev_in keeps tracking so a button held across clear is not a new press.
            r_state   <= S_IDLE;
            r_prev_in <= player_input;
            r_pend    <= '0;
            r_hit     <= '0;
            r_age     <= '0;
            r_valid   <= 1'b0;
            r_code    <= C_PERFECT;
            r_score   <= '0;
            r_combo   <= '0;
            r_max     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_prev_in <= player_input;
            r_pend    <= w_pend_nx;
            r_hit     <= w_hit_nx;
            r_age     <= w_age_nx;
            r_valid   <= w_fire;
            r_code    <= w_code;
            r_score   <= w_score_nx;
            r_combo   <= w_combo_nx;
            r_max     <= w_max_nx;
        end
    end

    assign judge_valid = r_valid;
    assign judge_code  = r_code;
    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max;

endmodule

// File: tb/tb_hit_judge.sv
// ---------------------------------------------------------------------------
// tb_hit_judge
// Directed bench for hit_judge. One instance with default parameters covers
// grading, timing windows, stray/miss handling, clear and reset; a second
// instance with SCORE_W=4, COMBO_W=2 covers score and combo saturation.
// ---------------------------------------------------------------------------
module tb_hit_judge;

    logic        clk;
    logic        resetn;
    logic        clear, beat_tick;
    logic [2:0]  notes, player_input;
    logic        d_valid;
    logic [1:0]  d_code;
    logic [15:0] d_score;
    logic [7:0]  d_combo, d_max;

    logic        s_clear, s_tick;
    logic [2:0]  s_notes, s_in;
    logic        s_valid;
    logic [1:0]  s_code;
    logic [3:0]  s_score;
    logic [1:0]  s_combo, s_max;

    int total = 0;
    int bad   = 0;

    hit_judge u_dut (
        .clk(clk), .resetn(resetn), .clear(clear), .beat_tick(beat_tick),
        .notes(notes), .player_input(player_input),
        .judge_valid(d_valid), .judge_code(d_code), .score(d_score),
        .combo(d_combo), .max_combo(d_max)
    );

    hit_judge #(.SCORE_W(4), .COMBO_W(2)) u_sat (
        .clk(clk), .resetn(resetn), .clear(s_clear), .beat_tick(s_tick),
        .notes(s_notes), .player_input(s_in),
        .judge_valid(s_valid), .judge_code(s_code), .score(s_score),
        .combo(s_combo), .max_combo(s_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic dchk(input string tag, input logic [31:0] v, input logic [31:0] c,
                        input logic [31:0] sc, input logic [31:0] cb, input logic [31:0] mx);
        chk({tag, ".valid"}, 32'(d_valid), v);
        chk({tag, ".code"},  32'(d_code),  c);
        chk({tag, ".score"}, 32'(d_score), sc);
        chk({tag, ".combo"}, 32'(d_combo), cb);
        chk({tag, ".max"},   32'(d_max),   mx);
    endtask

    // One note on lane 0 of the saturation instance, pressed at the given age.
    task automatic sat_note(input int age);
        s_notes = 3'b001;
        s_tick  = 1'b1;
        if (age == 0) s_in = 3'b001;
        cyc();
        s_tick  = 1'b0;
        s_notes = 3'b000;
        if (age > 0) begin
            repeat (age - 1) cyc();
            s_in = 3'b001;
            cyc();
        end
    endtask

    initial begin
        resetn = 1'b0; clear = 1'b0; beat_tick = 1'b0; notes = '0; player_input = '0;
        s_clear = 1'b0; s_tick = 1'b0; s_notes = '0; s_in = '0;
        cyc(); cyc();
        dchk("reset", 0, 0, 0, 0, 0);
        chk("sat.reset.score", 32'(s_score), 0);
        resetn = 1'b1;
        cyc();

        // Saturation instance: PERFECTs push combo into saturation.
        for (int i = 1; i <= 4; i++) begin
            sat_note(0);
            chk("sat.perf.valid", 32'(s_valid), 1);
            chk("sat.perf.score", 32'(s_score), 32'(3 * i));
            chk("sat.perf.combo", 32'(s_combo), (i > 3) ? 3 : 32'(i));
            s_in = '0;
            cyc();
        end
        for (int i = 1; i <= 2; i++) begin
            sat_note(3);
            chk("sat.good.code",  32'(s_code),  1);
            chk("sat.good.score", 32'(s_score), 32'(12 + i));
            s_in = '0;
            cyc();
        end
        sat_note(0);
        chk("sat.score14_perfect", 32'(s_score), 15);
        s_in = '0;
        cyc();
        sat_note(4);
        chk("sat.score15_good", 32'(s_score), 15);
        chk("sat.max", 32'(s_max), 3);
        s_in = '0;
        cyc();
        s_clear = 1'b1;
        cyc();
        s_clear = 1'b0;
        chk("sat.clear.score", 32'(s_score), 0);
        chk("sat.clear.max",   32'(s_max),   0);
        for (int i = 1; i <= 5; i++) begin
            sat_note(4);
            chk("sat.five.code",  32'(s_code),  1);
            chk("sat.five.combo", 32'(s_combo), (i > 3) ? 3 : 32'(i));
            chk("sat.five.score", 32'(s_score), 32'(i));
            s_in = '0;
            cyc();
        end

        // PERFECT at age 2.
        notes = 3'b001; beat_tick = 1'b1;
        cyc();
        chk("t1.tick.valid", 32'(d_valid), 0);
        notes = '0; beat_tick = 1'b0;
        cyc();
        chk("t1.age1.valid", 32'(d_valid), 0);
        player_input = 3'b001;
        cyc();
        dchk("t1.perfect", 1, 0, 3, 1, 1);
        player_input = '0;
        cyc();
        dchk("t1.after", 0, 0, 3, 1, 1);

        // Two-lane note: lane0 at age 1 (held), lane2 at age 4 -> single GOOD.
        notes = 3'b101; beat_tick = 1'b1;
        cyc();
        notes = '0; beat_tick = 1'b0;
        player_input = 3'b001;
        for (int a = 1; a <= 3; a++) begin
            cyc();
            chk("t2.partial.valid", 32'(d_valid), 0);
        end
        player_input = 3'b101;
        cyc();
        dchk("t2.good", 1, 1, 4, 2, 2);
        player_input = '0;
        cyc();

        // Tick with simultaneous exact press grades PERFECT immediately.
        notes = 3'b010; beat_tick = 1'b1; player_input = 3'b010;
        cyc();
        dchk("t3.instant1", 1, 0, 7, 3, 3);
        notes = '0; beat_tick = 1'b0; player_input = '0;
        cyc();
        chk("t3.gap.valid", 32'(d_valid), 0);
        notes = 3'b100; beat_tick = 1'b1; player_input = 3'b100;
        cyc();
        dchk("t3.instant2", 1, 0, 10, 4, 4);
        notes = '0; beat_tick = 1'b0; player_input = '0;
        cyc();

        // No press: MISS exactly GOOD_WIN edges after the tick.
        notes = 3'b010; beat_tick = 1'b1;
        cyc();
        notes = '0; beat_tick = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            cyc();
            chk("t3.wait.valid", 32'(d_valid), 0);
        end
        cyc();
        dchk("t3.timeout", 1, 2, 9, 0, 4);
        cyc();
        chk("t3.pulse_once", 32'(d_valid), 0);

        // Wrong lane at age 0 -> MISS, then a lone press -> STRAY.
        notes = 3'b001; beat_tick = 1'b1; player_input = 3'b010;
        cyc();
        dchk("t4.wrong", 1, 2, 8, 0, 4);
        notes = '0; beat_tick = 1'b0; player_input = '0;
        cyc();
        chk("t4.gap.valid", 32'(d_valid), 0);
        player_input = 3'b001;
        cyc();
        dchk("t4.stray", 1, 3, 7, 0, 4);
        player_input = '0;
        cyc();

        // New tick closes the pending note as MISS; new note then graded.
        notes = 3'b001; beat_tick = 1'b1;
        cyc();
        notes = '0; beat_tick = 1'b0;
        cyc();
        notes = 3'b100; beat_tick = 1'b1;
        cyc();
        dchk("t5.close", 1, 2, 6, 0, 4);
        notes = '0; beat_tick = 1'b0; player_input = 3'b100;
        cyc();
        dchk("t5.new", 1, 0, 9, 1, 4);
        player_input = '0;
        cyc();

        // Completion in a tick cycle grades the old note; new note opens clean.
        notes = 3'b001; beat_tick = 1'b1;
        cyc();
        notes = 3'b010; beat_tick = 1'b1; player_input = 3'b001;
        cyc();
        dchk("t5.complete_on_tick", 1, 0, 12, 2, 4);
        notes = '0; beat_tick = 1'b0; player_input = '0;
        cyc();
        chk("t5.newopen.valid", 32'(d_valid), 0);
        player_input = 3'b010;
        cyc();
        dchk("t5.second", 1, 0, 15, 3, 4);
        player_input = '0;
        cyc();

        // Clear with a button held across it: no STRAY afterwards.
        player_input = 3'b001; clear = 1'b1;
        cyc();
        dchk("t6.clear", 0, 0, 0, 0, 0);
        clear = 1'b0;
        cyc();
        chk("t6.held.valid", 32'(d_valid), 0);
        player_input = '0;
        cyc();
        player_input = 3'b010;
        cyc();
        dchk("t6.stray_at_zero", 1, 3, 0, 0, 0);
        player_input = '0;
        cyc();

        // Asynchronous reset mid-window.
        notes = 3'b001; beat_tick = 1'b1; player_input = 3'b001;
        cyc();
        dchk("t7.pre", 1, 0, 3, 1, 1);
        notes = '0; beat_tick = 1'b0; player_input = '0;
        cyc();
        notes = 3'b010; beat_tick = 1'b1;
        cyc();
        notes = '0; beat_tick = 1'b0;
        cyc();
        #3;
        resetn = 1'b0;
        #1;
        dchk("t7.async", 0, 0, 0, 0, 0);
        cyc();
        chk("t7.inreset.valid", 32'(d_valid), 0);
        resetn = 1'b1;
        player_input = 3'b010;
        cyc();
        dchk("t7.idle_after_reset", 1, 3, 0, 0, 0);
        player_input = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
